// File: rtl/floo_axi_txn_monitor.sv
// rtl/floo_axi_txn_monitor.sv - passive N-port AXI transaction monitor
// Tracks outstanding/completed traffic, runs a deadlock watchdog and a completion FSM.
module floo_axi_txn_monitor #(
  parameter int NumPorts       = 4,
  parameter int MaxOutstanding = 32,
  parameter int CntWidth       = 16,
  parameter int TimeoutCycles  = 10000,
  localparam int OutW  = $clog2(MaxOutstanding + 1),
  localparam int WdW   = $clog2(TimeoutCycles + 1),
  localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [NumPorts-1:0]      node_done_i,
  input  logic [NumPorts-1:0]      aw_valid_i,
  input  logic [NumPorts-1:0]      aw_ready_i,
  input  logic [NumPorts-1:0]      b_valid_i,
  input  logic [NumPorts-1:0]      b_ready_i,
  input  logic [NumPorts-1:0]      ar_valid_i,
  input  logic [NumPorts-1:0]      ar_ready_i,
  input  logic [NumPorts-1:0]      r_valid_i,
  input  logic [NumPorts-1:0]      r_ready_i,
  input  logic [NumPorts-1:0]      r_last_i,
  output logic [NumPorts*OutW-1:0] wr_outstanding_o,
  output logic [NumPorts*OutW-1:0] rd_outstanding_o,
  output logic [CntWidth-1:0]      wr_completed_o,
  output logic [CntWidth-1:0]      rd_completed_o,
  output logic [2:0]               state_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [2:0]               err_code_o,
  output logic [PortW-1:0]         err_port_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_RUN = 3'd1, ST_DRAIN = 3'd2, ST_DONE = 3'd3, ST_ERROR = 3'd4
  } state_e;

  localparam int PopW = $clog2(NumPorts + 1);
  localparam int SumW = CntWidth + PopW;
  localparam logic [OutW-1:0] MaxCnt = OutW'(MaxOutstanding);

  state_e               r_state;
  logic [OutW-1:0]      r_wr_cnt [NumPorts];
  logic [OutW-1:0]      r_rd_cnt [NumPorts];
  logic [OutW-1:0]      w_wr_nxt [NumPorts];
  logic [OutW-1:0]      w_rd_nxt [NumPorts];
  logic [CntWidth-1:0]  r_wr_done, r_rd_done, w_wr_done_nxt, w_rd_done_nxt;
  logic [WdW-1:0]       r_wd;
  logic [2:0]           r_err_code;
  logic [PortW-1:0]     r_err_port;

  logic [NumPorts-1:0]  w_aw_hs, w_b_hs, w_ar_hs, w_rl_hs, w_port_hs;
  logic [NumPorts-1:0]  w_wr_uf, w_wr_of, w_rd_uf, w_rd_of, w_cnt_nz;
  logic                 w_any_hs, w_all_done, w_wd_run, w_timeout;
  logic                 w_err;
  logic [2:0]           w_err_code;
  logic [PortW-1:0]     w_err_port;
  logic [SumW-1:0]      w_wr_sum, w_rd_sum;

  // Underflow and overflow leave the counter unchanged (held at 0 / saturated).
  function automatic logic [OutW-1:0] f_next(input logic [OutW-1:0] cnt,
                                             input logic op, input logic cl);
    if (op && !cl && cnt != MaxCnt) return cnt + OutW'(1);
    if (cl && !op && cnt != '0)     return cnt - OutW'(1);
    return cnt;
  endfunction

  function automatic logic [PopW-1:0] f_pop(input logic [NumPorts-1:0] v);
    logic [PopW-1:0] n;
    n = '0;
    for (int i = 0; i < NumPorts; i++) n = n + PopW'(v[i]);
    return n;
  endfunction

  assign w_aw_hs   = aw_valid_i & aw_ready_i;
  assign w_b_hs    = b_valid_i & b_ready_i;
  assign w_ar_hs   = ar_valid_i & ar_ready_i;
  assign w_rl_hs   = r_valid_i & r_ready_i & r_last_i;
  assign w_port_hs = w_aw_hs | w_b_hs | w_ar_hs | w_rl_hs;
  assign w_any_hs  = |w_port_hs;
  assign w_all_done = &node_done_i;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign w_wr_uf[p]  = w_b_hs[p] & ~w_aw_hs[p] & (r_wr_cnt[p] == '0);
    assign w_wr_of[p]  = w_aw_hs[p] & ~w_b_hs[p] & (r_wr_cnt[p] == MaxCnt);
    assign w_rd_uf[p]  = w_rl_hs[p] & ~w_ar_hs[p] & (r_rd_cnt[p] == '0);
    assign w_rd_of[p]  = w_ar_hs[p] & ~w_rl_hs[p] & (r_rd_cnt[p] == MaxCnt);
    assign w_wr_nxt[p] = f_next(r_wr_cnt[p], w_aw_hs[p], w_b_hs[p]);
    assign w_rd_nxt[p] = f_next(r_rd_cnt[p], w_ar_hs[p], w_rl_hs[p]);
    assign w_cnt_nz[p] = (r_wr_cnt[p] != '0) | (r_rd_cnt[p] != '0);
    assign wr_outstanding_o[p*OutW +: OutW] = r_wr_cnt[p];
    assign rd_outstanding_o[p*OutW +: OutW] = r_rd_cnt[p];
  end

  assign w_wr_sum = SumW'(r_wr_done) + SumW'(f_pop(w_b_hs));
  assign w_rd_sum = SumW'(r_rd_done) + SumW'(f_pop(w_rl_hs));
  assign w_wr_done_nxt = (w_wr_sum > SumW'({CntWidth{1'b1}})) ? '1 : w_wr_sum[CntWidth-1:0];
  assign w_rd_done_nxt = (w_rd_sum > SumW'({CntWidth{1'b1}})) ? '1 : w_rd_sum[CntWidth-1:0];

  assign w_wd_run  = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (|w_cnt_nz) && !w_any_hs;
  assign w_timeout = w_wd_run && (r_wd == WdW'(TimeoutCycles - 1));

  // Lowest port wins; within a port underflow > overflow > late traffic; timeout last.
  always_comb begin
    w_err      = 1'b0;
    w_err_code = 3'd0;
    w_err_port = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (!w_err) begin
        if (w_wr_uf[p] || w_rd_uf[p]) begin
          w_err = 1'b1; w_err_code = 3'd1; w_err_port = PortW'(p);
        end else if (w_wr_of[p] || w_rd_of[p]) begin
          w_err = 1'b1; w_err_code = 3'd2; w_err_port = PortW'(p);
        end else if (r_state == ST_DONE && w_port_hs[p]) begin
          w_err = 1'b1; w_err_code = 3'd4; w_err_port = PortW'(p);
        end
      end
    end
    if (!w_err && w_timeout) begin
      w_err      = 1'b1;
      w_err_code = 3'd3;
      w_err_port = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      for (int p = 0; p < NumPorts; p++) begin
        r_wr_cnt[p] <= '0;
        r_rd_cnt[p] <= '0;
      end
      r_wr_done  <= '0;
      r_rd_done  <= '0;
      r_wd       <= '0;
      r_state    <= ST_IDLE;
      r_err_code <= 3'd0;
      r_err_port <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        r_wr_cnt[p] <= w_wr_nxt[p];
        r_rd_cnt[p] <= w_rd_nxt[p];
      end
      r_wr_done <= w_wr_done_nxt;
      r_rd_done <= w_rd_done_nxt;
      r_wd      <= w_wd_run ? r_wd + WdW'(1) : '0;
      if (w_err && r_state != ST_ERROR) begin
        r_state    <= ST_ERROR;
        r_err_code <= w_err_code;
        r_err_port <= w_err_port;
      end else begin
        case (r_state)
          ST_IDLE:  if (w_any_hs) r_state <= ST_RUN;
          ST_RUN:   if (w_all_done) r_state <= ST_DRAIN;
          ST_DRAIN: if (!w_all_done) r_state <= ST_RUN;
                    else if (!(|w_cnt_nz)) r_state <= ST_DONE;
          default:  r_state <= r_state;
        endcase
      end
    end
  end

  assign wr_completed_o = r_wr_done;
  assign rd_completed_o = r_rd_done;
  assign state_o        = r_state;
  assign done_o         = (r_state == ST_DONE);
  assign error_o        = (r_state == ST_ERROR);
  assign err_code_o     = r_err_code;
  assign err_port_o     = r_err_port;

endmodule
